dcache_event_monitor: RTL and testbench

//  Synthesizable, parametrised monitor for the data-cache CPU-side port (p1_*). Classifies every access as

---
 rtl/dcache_event_monitor_if.sv | 52 +++++
 rtl/dcache_event_monitor.sv | 254 +++++++++++++++++++++++++
 tb/tb_dcache_event_monitor.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_event_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_event_monitor_if
//  Purpose  : Bundles the data-cache CPU-side tap signals and the trace-record
//             valid/ready stream of dcache_event_monitor.
//  Modports : master - the monitor (samples taps and ready, drives trace_*)
//             slave  - the surrounding system / trace consumer
//  Signals  : stall_i, idle_i, dirty_i, mem_read_i, mem_write_i, addr_i,
//             wdata_i, rdata_i (taps); trace_valid_o, trace_ready_i,
//             trace_ts_o, trace_kind_o, trace_wb_o, trace_addr_o,
//             trace_data_o (trace stream)
//  Revision : 1.0 - initial release
// ============================================================================
interface dcache_event_monitor_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TS_W   = 32
);
    // cache tap
    logic              stall_i;
    logic              idle_i;
    logic              dirty_i;
    logic              mem_read_i;
    logic              mem_write_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] wdata_i;
    logic [DATA_W-1:0] rdata_i;

    // trace stream
    logic              trace_valid_o;
    logic              trace_ready_i;
    logic [TS_W-1:0]   trace_ts_o;
    logic [1:0]        trace_kind_o;
    logic              trace_wb_o;
    logic [ADDR_W-1:0] trace_addr_o;
    logic [DATA_W-1:0] trace_data_o;

    modport master (
        input  stall_i, idle_i, dirty_i, mem_read_i, mem_write_i,
               addr_i, wdata_i, rdata_i, trace_ready_i,
        output trace_valid_o, trace_ts_o, trace_kind_o, trace_wb_o,
               trace_addr_o, trace_data_o
    );

    modport slave (
        output stall_i, idle_i, dirty_i, mem_read_i, mem_write_i,
               addr_i, wdata_i, rdata_i, trace_ready_i,
        input  trace_valid_o, trace_ts_o, trace_kind_o, trace_wb_o,
               trace_addr_o, trace_data_o
    );
endinterface
`default_nettype wire

// File: rtl/dcache_event_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_event_monitor
//  Purpose  : Passive monitor of the data-cache CPU-side port. Classifies each
//             access as read/write hit/miss, flags dirty write-backs, keeps
//             saturating per-class counters, timestamps every event and queues
//             the records in a first-word-fall-through trace FIFO.
//  Ports    : clk_i, rst_i (sync, active low), enable_i, clear_i,
//             bus (taps + trace stream, master modport),
//             rd_hit_cnt_o, rd_miss_cnt_o, wr_hit_cnt_o, wr_miss_cnt_o,
//             wb_cnt_o, drop_cnt_o (event counters), level_o (FIFO occupancy)
//  Revision : 1.0 - initial release
// ============================================================================
module dcache_event_monitor #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TS_W   = 32,
    parameter int CNT_W  = 32,
    parameter int DEPTH  = 16
) (
    input  wire logic                     clk_i,
    input  wire logic                     rst_i,
    input  wire logic                     enable_i,
    input  wire logic                     clear_i,
    dcache_event_monitor_if.master        bus,
    output logic [CNT_W-1:0]              rd_hit_cnt_o,
    output logic [CNT_W-1:0]              rd_miss_cnt_o,
    output logic [CNT_W-1:0]              wr_hit_cnt_o,
    output logic [CNT_W-1:0]              wr_miss_cnt_o,
    output logic [CNT_W-1:0]              wb_cnt_o,
    output logic [CNT_W-1:0]              drop_cnt_o,
    output logic [$clog2(DEPTH):0]        level_o
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_lvl_w = c_ptr_w + 1;
    // record layout: {ts, kind, wb, addr, data}
    localparam int c_rec_w = TS_W + 3 + ADDR_W + DATA_W;
    localparam logic [c_lvl_w-1:0] c_full = c_lvl_w'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MISS = 1'b1
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q,  state_d;
    logic [TS_W-1:0]     ts_q,     ts_d;
    logic [TS_W-1:0]     p_ts_q,   p_ts_d;
    logic [ADDR_W-1:0]   p_addr_q, p_addr_d;
    logic [1:0]          p_kind_q, p_kind_d;
    logic                p_wb_q,   p_wb_d;
    logic [DATA_W-1:0]   p_data_q, p_data_d;

    logic [c_rec_w-1:0]  mem_q [DEPTH];
    logic [c_rec_w-1:0]  mem_d [DEPTH];
    logic [c_ptr_w-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_lvl_w-1:0]  level_q,  level_d;

    logic [CNT_W-1:0]    rd_hit_q,  rd_hit_d;
    logic [CNT_W-1:0]    rd_miss_q, rd_miss_d;
    logic [CNT_W-1:0]    wr_hit_q,  wr_hit_d;
    logic [CNT_W-1:0]    wr_miss_q, wr_miss_d;
    logic [CNT_W-1:0]    wb_q,      wb_d;
    logic [CNT_W-1:0]    drop_q,    drop_d;

    // ------------------------------------------------------------------
    // Event classification
    // ------------------------------------------------------------------
    logic                w_access;
    logic                w_hit;
    logic                w_miss_start;
    logic                w_miss_end;
    logic                w_push;
    logic [c_rec_w-1:0]  w_rec;
    logic                w_pop;
    logic                w_full;
    logic                w_accept;
    logic                w_drop;

    always_comb begin : p_classify
        w_access     = bus.mem_read_i | bus.mem_write_i;
        w_hit        = enable_i & w_access & ~bus.stall_i & (state_q == ST_IDLE);
        w_miss_start = enable_i & w_access &  bus.stall_i & bus.idle_i
                     & (state_q == ST_IDLE);
        // The completing cycle of a miss pushes the latched record only;
        // it is never also counted as a hit because w_hit needs ST_IDLE.
        w_miss_end   = enable_i & (state_q == ST_MISS) & ~bus.stall_i;
        w_push       = w_hit | w_miss_end;

        if (w_miss_end) begin
            // read misses report the data returned on the release cycle
            w_rec = {p_ts_q, p_kind_q, p_wb_q, p_addr_q,
                     p_kind_q[1] ? p_data_q : bus.rdata_i};
        end else begin
            w_rec = {ts_q, bus.mem_write_i, 1'b0, 1'b0, bus.addr_i,
                     bus.mem_write_i ? bus.wdata_i : bus.rdata_i};
        end

        w_pop    = (level_q != '0) & bus.trace_ready_i;
        w_full   = (level_q == c_full);
        // a pop in the same cycle frees the slot the push needs
        w_accept = w_push & (~w_full | w_pop);
        w_drop   = w_push &  w_full & ~w_pop;
    end

    // ------------------------------------------------------------------
    // Miss tracking FSM
    // ------------------------------------------------------------------
    always_comb begin : p_fsm
        state_d  = state_q;
        p_ts_d   = p_ts_q;
        p_addr_d = p_addr_q;
        p_kind_d = p_kind_q;
        p_wb_d   = p_wb_q;
        p_data_d = p_data_q;

        case (state_q)
            ST_IDLE: begin
                if (w_miss_start) begin
                    state_d  = ST_MISS;
                    p_ts_d   = ts_q;
                    p_addr_d = bus.addr_i;
                    p_kind_d = {bus.mem_write_i, 1'b1};
                    p_wb_d   = bus.dirty_i;
                    p_data_d = bus.wdata_i;
                end
            end
            ST_MISS: begin
                // disabling the monitor abandons the outstanding miss
                if (!enable_i || !bus.stall_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (clear_i) begin
            state_d  = ST_IDLE;
            p_ts_d   = '0;
            p_addr_d = '0;
            p_kind_d = '0;
            p_wb_d   = 1'b0;
            p_data_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Timestamp, counters, FIFO
    // ------------------------------------------------------------------
    always_comb begin : p_datapath
        ts_d      = enable_i ? ts_q + TS_W'(1) : ts_q;

        rd_hit_d  = sat_inc(rd_hit_q,  w_hit & ~bus.mem_write_i);
        wr_hit_d  = sat_inc(wr_hit_q,  w_hit &  bus.mem_write_i);
        rd_miss_d = sat_inc(rd_miss_q, w_miss_end & ~p_kind_q[1]);
        wr_miss_d = sat_inc(wr_miss_q, w_miss_end &  p_kind_q[1]);
        wb_d      = sat_inc(wb_q,      w_miss_end &  p_wb_q);
        drop_d    = sat_inc(drop_q,    w_drop);

        mem_d     = mem_q;
        if (w_accept) begin
            mem_d[wr_ptr_q] = w_rec;
        end
        wr_ptr_d  = w_accept ? wr_ptr_q + c_ptr_w'(1) : wr_ptr_q;
        rd_ptr_d  = w_pop    ? rd_ptr_q + c_ptr_w'(1) : rd_ptr_q;

        level_d   = level_q;
        if (w_accept && !w_pop) begin
            level_d = level_q + c_lvl_w'(1);
        end else if (!w_accept && w_pop) begin
            level_d = level_q - c_lvl_w'(1);
        end

        if (clear_i) begin
            ts_d      = '0;
            rd_hit_d  = '0;
            wr_hit_d  = '0;
            rd_miss_d = '0;
            wr_miss_d = '0;
            wb_d      = '0;
            drop_d    = '0;
            mem_d     = '{default: '0};
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin : p_regs
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            ts_q      <= '0;
            p_ts_q    <= '0;
            p_addr_q  <= '0;
            p_kind_q  <= '0;
            p_wb_q    <= 1'b0;
            p_data_q  <= '0;
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_hit_q  <= '0;
            rd_miss_q <= '0;
            wr_hit_q  <= '0;
            wr_miss_q <= '0;
            wb_q      <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            ts_q      <= ts_d;
            p_ts_q    <= p_ts_d;
            p_addr_q  <= p_addr_d;
            p_kind_q  <= p_kind_d;
            p_wb_q    <= p_wb_d;
            p_data_q  <= p_data_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            rd_hit_q  <= rd_hit_d;
            rd_miss_q <= rd_miss_d;
            wr_hit_q  <= wr_hit_d;
            wr_miss_q <= wr_miss_d;
            wb_q      <= wb_d;
            drop_q    <= drop_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: FIFO head falls through directly from storage
    // ------------------------------------------------------------------
    assign bus.trace_valid_o = (level_q != '0);
    assign {bus.trace_ts_o, bus.trace_kind_o, bus.trace_wb_o,
            bus.trace_addr_o, bus.trace_data_o} = mem_q[rd_ptr_q];

    assign rd_hit_cnt_o  = rd_hit_q;
    assign rd_miss_cnt_o = rd_miss_q;
    assign wr_hit_cnt_o  = wr_hit_q;
    assign wr_miss_cnt_o = wr_miss_q;
    assign wb_cnt_o      = wb_q;
    assign drop_cnt_o    = drop_q;
    assign level_o       = level_q;

endmodule
`default_nettype wire

// File: tb/tb_dcache_event_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dcache_event_monitor
//  Purpose  : Self-checking bench for dcache_event_monitor (DEPTH=4, CNT_W=3,
//             TS_W=8) with a queue-based reference model and directed vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_event_monitor;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TS_W   = 8;
    localparam int CNT_W  = 3;
    localparam int DEPTH  = 4;
    localparam int SAT    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    logic clear;

    logic [CNT_W-1:0]         rd_hit, rd_miss, wr_hit, wr_miss, wb, drop;
    logic [$clog2(DEPTH):0]   level;

    dcache_event_monitor_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TS_W(TS_W)) bus ();

    dcache_event_monitor #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TS_W(TS_W), .CNT_W(CNT_W), .DEPTH(DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .enable_i      (enable),
        .clear_i       (clear),
        .bus           (bus),
        .rd_hit_cnt_o  (rd_hit),
        .rd_miss_cnt_o (rd_miss),
        .wr_hit_cnt_o  (wr_hit),
        .wr_miss_cnt_o (wr_miss),
        .wb_cnt_o      (wb),
        .drop_cnt_o    (drop),
        .level_o       (level)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: list of records plus plain integer counters
    // ------------------------------------------------------------------
    typedef struct {
        int unsigned ts;
        int unsigned kind;
        int unsigned wb;
        int unsigned addr;
        int unsigned data;
    } rec_t;

    rec_t        m_q[$];
    rec_t        m_pend_rec;
    rec_t        m_new;
    bit          m_pend;
    int unsigned m_ts;
    int          m_rd_hit, m_rd_miss, m_wr_hit, m_wr_miss, m_wb, m_drop;
    bit          m_push, m_pop;

    function automatic int sat1(input int c);
        return (c < SAT) ? c + 1 : c;
    endfunction

    always @(posedge clk) begin
        if (!rst_n || clear) begin
            m_q.delete();
            m_pend = 0;
            m_ts = 0;
            m_rd_hit = 0; m_rd_miss = 0; m_wr_hit = 0; m_wr_miss = 0; m_wb = 0; m_drop = 0;
        end else begin
            m_push = 0;
            m_pop  = (m_q.size() != 0) && bus.trace_ready_i;
            if (m_pend) begin
                if (!enable) begin
                    m_pend = 0;
                end else if (!bus.stall_i) begin
                    m_new = m_pend_rec;
                    if (m_new.kind == 1) m_new.data = bus.rdata_i;
                    m_push = 1;
                    m_pend = 0;
                    if (m_new.kind == 3) m_wr_miss = sat1(m_wr_miss);
                    else                 m_rd_miss = sat1(m_rd_miss);
                    if (m_new.wb != 0)   m_wb = sat1(m_wb);
                end
            end else if (enable && (bus.mem_read_i || bus.mem_write_i)) begin
                if (!bus.stall_i) begin
                    m_new.ts   = m_ts;
                    m_new.kind = bus.mem_write_i ? 2 : 0;
                    m_new.wb   = 0;
                    m_new.addr = bus.addr_i;
                    m_new.data = bus.mem_write_i ? bus.wdata_i : bus.rdata_i;
                    m_push = 1;
                    if (bus.mem_write_i) m_wr_hit = sat1(m_wr_hit);
                    else                 m_rd_hit = sat1(m_rd_hit);
                end else if (bus.idle_i) begin
                    m_pend          = 1;
                    m_pend_rec.ts   = m_ts;
                    m_pend_rec.kind = bus.mem_write_i ? 3 : 1;
                    m_pend_rec.wb   = bus.dirty_i;
                    m_pend_rec.addr = bus.addr_i;
                    m_pend_rec.data = bus.wdata_i;
                end
            end
            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_new);
                else                    m_drop = sat1(m_drop);
            end
            if (enable) m_ts = (m_ts + 1) % (1 << TS_W);
        end
    end

    // per-cycle comparison, mid-cycle
    always @(negedge clk) begin
        chk("cmp_valid",   bus.trace_valid_o, (m_q.size() != 0));
        chk("cmp_level",   level,   m_q.size());
        chk("cmp_rd_hit",  rd_hit,  m_rd_hit);
        chk("cmp_rd_miss", rd_miss, m_rd_miss);
        chk("cmp_wr_hit",  wr_hit,  m_wr_hit);
        chk("cmp_wr_miss", wr_miss, m_wr_miss);
        chk("cmp_wb",      wb,      m_wb);
        chk("cmp_drop",    drop,    m_drop);
        if (m_q.size() != 0) begin
            chk("cmp_ts",   bus.trace_ts_o,   m_q[0].ts);
            chk("cmp_kind", bus.trace_kind_o, m_q[0].kind);
            chk("cmp_wb_f", bus.trace_wb_o,   m_q[0].wb);
            chk("cmp_addr", bus.trace_addr_o, m_q[0].addr);
            chk("cmp_data", bus.trace_data_o, m_q[0].data);
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed expectations
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.mem_read_i  = 0;
        bus.mem_write_i = 0;
        bus.stall_i     = 0;
        bus.idle_i      = 1;
        bus.dirty_i     = 0;
    endtask

    initial begin
        rst_n = 0; enable = 0; clear = 0;
        idle_bus();
        bus.addr_i = 0; bus.wdata_i = 0; bus.rdata_i = 0; bus.trace_ready_i = 0;
        tick(); tick();
        chk("reset_valid", bus.trace_valid_o, 0);
        chk("reset_level", level, 0);
        chk("reset_rd_hit", rd_hit, 0);

        // 1: read hit at ts=7
        rst_n = 1; enable = 1;
        repeat (7) tick();
        bus.mem_read_i = 1; bus.addr_i = 32'h40; bus.rdata_i = 5;
        tick();
        idle_bus();
        chk("t1_valid", bus.trace_valid_o, 1);
        chk("t1_kind",  bus.trace_kind_o, 0);
        chk("t1_ts",    bus.trace_ts_o, 7);
        chk("t1_addr",  bus.trace_addr_o, 32'h40);
        chk("t1_data",  bus.trace_data_o, 5);
        chk("t1_rd_hit", rd_hit, 1);
        bus.trace_ready_i = 1; tick(); bus.trace_ready_i = 0;
        chk("t1_popped", bus.trace_valid_o, 0);

        // 2: dirty write miss starting at ts=9
        bus.mem_write_i = 1; bus.addr_i = 32'h400; bus.wdata_i = 32'hAA;
        bus.stall_i = 1; bus.idle_i = 1; bus.dirty_i = 1;
        repeat (10) tick();
        chk("t2_no_early", bus.trace_valid_o, 0);
        bus.stall_i = 0;
        tick();
        idle_bus();
        chk("t2_level",   level, 1);
        chk("t2_kind",    bus.trace_kind_o, 3);
        chk("t2_wb",      bus.trace_wb_o, 1);
        chk("t2_ts",      bus.trace_ts_o, 9);
        chk("t2_data",    bus.trace_data_o, 32'hAA);
        chk("t2_wr_miss", wr_miss, 1);
        chk("t2_wb_cnt",  wb, 1);
        chk("t2_wr_hit",  wr_hit, 0);
        bus.trace_ready_i = 1; tick(); bus.trace_ready_i = 0;

        // 3: clean read miss, data on release cycle
        bus.mem_read_i = 1; bus.addr_i = 32'h80; bus.rdata_i = 0;
        bus.stall_i = 1; bus.dirty_i = 0;
        repeat (8) tick();
        bus.stall_i = 0; bus.rdata_i = 32'h1234;
        tick();
        idle_bus();
        chk("t3_level",   level, 1);
        chk("t3_kind",    bus.trace_kind_o, 1);
        chk("t3_wb",      bus.trace_wb_o, 0);
        chk("t3_data",    bus.trace_data_o, 32'h1234);
        chk("t3_rd_miss", rd_miss, 1);
        chk("t3_rd_hit",  rd_hit, 1);
        bus.trace_ready_i = 1; tick(); bus.trace_ready_i = 0;

        // enable dropped during a pending miss: no record
        bus.mem_read_i = 1; bus.addr_i = 32'h90; bus.stall_i = 1;
        repeat (2) tick();
        enable = 0; tick();
        idle_bus(); enable = 1; tick();
        chk("abort_level", level, 0);
        chk("abort_rd_miss", rd_miss, 1);

        clear = 1; tick(); clear = 0;
        chk("clr_level", level, 0);
        chk("clr_wb", wb, 0);

        // 4: overflow with ready=0
        for (int i = 0; i < 6; i++) begin
            bus.mem_read_i = 1; bus.addr_i = 32'h100 + 4 * i; bus.rdata_i = i;
            tick();
        end
        idle_bus();
        chk("t4_level",  level, 4);
        chk("t4_drop",   drop, 2);
        chk("t4_rd_hit", rd_hit, 6);
        bus.trace_ready_i = 1;
        for (int i = 0; i < 4; i++) begin
            chk("t4_order", bus.trace_addr_o, 32'h100 + 4 * i);
            tick();
        end
        bus.trace_ready_i = 0;
        chk("t4_drained", bus.trace_valid_o, 0);

        // 5: refill (first access has both rd and wr -> write), then pop+hit while full
        for (int i = 0; i < 5; i++) begin
            bus.mem_read_i = 1; bus.mem_write_i = (i == 0);
            bus.addr_i = 32'h200 + 4 * i; bus.wdata_i = 32'h55; bus.rdata_i = 32'h10 + i;
            tick();
        end
        chk("t5_wr_hit", wr_hit, 1);
        chk("t5_drop3",  drop, 3);
        bus.mem_write_i = 0; bus.addr_i = 32'h300; bus.trace_ready_i = 1;
        tick();
        idle_bus();
        chk("t5_level",  level, 4);
        chk("t5_drop",   drop, 3);
        chk("t5_sat",    rd_hit, SAT);
        repeat (3) tick();
        chk("t5_last",   bus.trace_addr_o, 32'h300);
        tick();
        bus.trace_ready_i = 0;
        chk("t5_empty",  bus.trace_valid_o, 0);

        // 6: clear during a miss, then reset mid-stream
        bus.mem_write_i = 1; bus.addr_i = 32'h500; bus.stall_i = 1; bus.dirty_i = 1;
        repeat (3) tick();
        clear = 1; tick(); clear = 0;
        idle_bus(); tick();
        chk("t6_clr_level", level, 0);
        chk("t6_clr_wmiss", wr_miss, 0);
        chk("t6_clr_valid", bus.trace_valid_o, 0);
        bus.mem_read_i = 1; bus.addr_i = 32'h600;
        repeat (2) tick();
        rst_n = 0; tick(); rst_n = 1;
        idle_bus();
        chk("t6_rst_level", level, 0);
        chk("t6_rst_rdhit", rd_hit, 0);
        chk("t6_rst_valid", bus.trace_valid_o, 0);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
